array_wr_sched: RTL
===================

ARRAY_WR_SCHED -- requirements
Module: array_wr_sched

Interface
REQ-001 The block SHALL have parameters ADDRBIT, default 9, address width.
REQ-002 The block SHALL have parameters DEPTH, default 512, number of array words.
REQ-003 The block SHALL have parameters WIDTH, default 32, data width.
REQ-004 Port clk, input, 1, single clock for all logic.
REQ-005 Port rst_, input, 1, asynchronous active-low reset.
REQ-006 Port req0, input, 1, requester 0 write request; held with wa0/di0 until gnt0.
REQ-007 Port wa0, input, ADDRBIT, requester 0 write address.
REQ-008 Port di0, input, WIDTH, requester 0 write data.
REQ-009 Port gnt0, output, 1, requester 0 grant, combinational, same cycle as accepted req0.
REQ-010 Ports req1/wa1/di1/gnt1 SHALL mirror REQ-006..REQ-009 for requester 1.
REQ-011 Port clr_start, input, 1, single-cycle pulse starting a memory clear sweep.
REQ-012 Port clr_busy, output, 1, high while the clear sweep owns the write port.
REQ-013 Ports we (1), wa (ADDRBIT), di (WIDTH), outputs, registered write port to the 1R1W array.

Function
REQ-014 The block SHALL grant at most one of gnt0/gnt1 per cycle, and only when the corresponding req is high and clr_busy is low.
REQ-015 Arbitration SHALL be round-robin: with both requesting, grant goes to the requester not granted most recently; a single requester is granted every cycle it requests.
REQ-016 A grant in cycle N SHALL produce we=1 with the granted wa/di in cycle N+1 (latency 1); with no grant, we=0 in cycle N+1.
REQ-017 While we=0, wa and di SHALL hold their previous values.
REQ-018 Clear FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clr_start; CLEAR->IDLE after issuing address DEPTH-1.
REQ-019 On the IDLE->CLEAR edge the sweep counter SHALL load 0; clr_busy SHALL be high from the cycle after clr_start through the cycle the last clear write is presented.
REQ-020 In CLEAR the block SHALL issue one write per cycle: we=1, wa=counter, di=0, counter incrementing by 1, for exactly DEPTH consecutive cycles.
REQ-021 The counter SHALL end at DEPTH-1 (no wrap to 0 issued); DEPTH less than 2^ADDRBIT SHALL be supported.
REQ-022 clr_start while in CLEAR SHALL be ignored (no restart, no extension).
REQ-023 clr_start coinciding with a request SHALL let that cycle's grant proceed; the request's write appears in cycle N+1, and clear writes start in cycle N+2.
REQ-024 Requests during CLEAR SHALL be held off (no grant) and SHALL be granted per round-robin from the first cycle clr_busy is low.
REQ-025 Round-robin pointer SHALL be unchanged by the clear sweep.

Reset
REQ-026 On rst_ low, asynchronously: we=0, wa=0, di=0, clr_busy=0, FSM=IDLE, counter=0, round-robin pointer favours requester 0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep; no clear write is issued after reset release without a new clr_start.
REQ-028 gnt0/gnt1 SHALL be 0 while rst_ is low.

Configuration
REQ-029 Macro ARRAY_WR_SCHED_CLR_EN SHALL compile in the clear FSM and counter (REQ-018..REQ-025).
REQ-030 Without ARRAY_WR_SCHED_CLR_EN, clr_start SHALL be ignored, clr_busy SHALL be constant 0, and the FSM and counter SHALL not be built; arbitration behaviour is otherwise identical.

Verification
REQ-031 req0=1 wa0=5 di0=0xA5A5A5A5 alone for 1 cycle -> gnt0=1 same cycle; next cycle we=1 wa=5 di=0xA5A5A5A5.
REQ-032 req0,req1 both held high 4 cycles after reset -> grants 0,1,0,1; we high 4 consecutive cycles with alternating addresses.
REQ-033 CLR_EN, DEPTH=8, ADDRBIT=4: clr_start pulse -> we=1, di=0, wa=0..7 on 8 consecutive cycles, clr_busy high those 8 cycles, then we=0.
REQ-034 CLR_EN, req1 held during sweep -> gnt1=0 throughout; gnt1=1 in first cycle clr_busy=0; its write appears the following cycle.
REQ-035 CLR_EN, rst_ low at sweep address 3 -> outputs reset immediately; after release, we stays 0 with no requests.
REQ-036 Without CLR_EN, clr_start pulsed with req0 high -> clr_busy stays 0, gnt0=1 every cycle, no zero writes.

Source files
------------

// File: rtl/array_wr_sched.sv
// Two-requester round-robin write scheduler in front of a 1R1W array port.
// Optional memory clear sweep compiled in with `define ARRAY_WR_SCHED_CLR_EN.
module array_wr_sched #(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               req0,
    input  logic [ADDRBIT-1:0] wa0,
    input  logic [WIDTH-1:0]   di0,
    output logic               gnt0,
    input  logic               req1,
    input  logic [ADDRBIT-1:0] wa1,
    input  logic [WIDTH-1:0]   di1,
    output logic               gnt1,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               we,
    output logic [ADDRBIT-1:0] wa,
    output logic [WIDTH-1:0]   di
);

    logic               last1_r;
    logic               gnt0_s;
    logic               gnt1_s;
    logic               clr_wr_s;
    logic [ADDRBIT-1:0] clr_addr_s;

`ifdef ARRAY_WR_SCHED_CLR_EN
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    clr_state_t         state_r;
    logic [ADDRBIT-1:0] cnt_r;
    logic               busy_r;

    // Clear sweep FSM; busy stays up one extra cycle so it covers the last registered clear write.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r <= IDLE;
            cnt_r   <= {ADDRBIT{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= clr_start;
                    if (clr_start) begin
                        state_r <= CLEAR;
                        cnt_r   <= {ADDRBIT{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CLEAR: begin
                    busy_r <= 1'b1;
                    if (cnt_r == ADDRBIT'(DEPTH - 1)) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(ADDRBIT-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {ADDRBIT{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_wr_s   = (state_r == CLEAR);
    assign clr_addr_s = cnt_r;
    assign clr_busy   = busy_r;
`else
    localparam int unused_depth_lp = DEPTH;
    logic unused_clr_start_s;

    assign unused_clr_start_s = clr_start;
    assign clr_wr_s           = 1'b0;
    assign clr_addr_s         = {ADDRBIT{1'b0}};
    assign clr_busy           = 1'b0;
`endif

    // Round-robin grant: on contention requester 0 wins only if requester 1 was granted last.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_ || clr_busy) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (req0 && (!req1 || last1_r)) begin
            gnt0_s = 1'b1;
        end else if (req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign gnt0 = gnt0_s;
    assign gnt1 = gnt1_s;

    // Registered write port; address and data hold whenever no write is issued.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            we      <= 1'b0;
            wa      <= {ADDRBIT{1'b0}};
            di      <= {WIDTH{1'b0}};
            last1_r <= 1'b1;
        end else if (clr_wr_s) begin
            we <= 1'b1;
            wa <= clr_addr_s;
            di <= {WIDTH{1'b0}};
        end else if (gnt0_s) begin
            we      <= 1'b1;
            wa      <= wa0;
            di      <= di0;
            last1_r <= 1'b0;
        end else if (gnt1_s) begin
            we      <= 1'b1;
            wa      <= wa1;
            di      <= di1;
            last1_r <= 1'b1;
        end else begin
            we <= 1'b0;
        end
    end

endmodule
